// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding an 8N1 (or 8E1/8O1) serializer.
// Bit timing is driven by a 16x tick; all state lives in the sys_clk domain.
module uart_transmitter #(
    parameter int SAMPLE_TIMES = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tx_clk_en,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_overflow,
    input  logic       tx_overflow_clear,
    output logic       tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (SAMPLE_TIMES > 1) ? $clog2(SAMPLE_TIMES) : 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_TICK = TW'(SAMPLE_TIMES - 1);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    logic [2:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          w_last;

    assign w_push  = tx_wr & ~tx_full;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_last  = tx_clk_en && (r_tick == LAST_TICK);
    assign tx_busy = (r_state != S_IDLE);

    // Pops happen only on a tick: from IDLE, or back-to-back at the end of STOP
    always_comb begin
        w_pop = 1'b0;
        if (tx_clk_en && !tx_empty) begin
            if (r_state == S_IDLE)
                w_pop = 1'b1;
            else if (r_state == S_STOP && r_tick == LAST_TICK)
                w_pop = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            tx_full     <= 1'b0;
            tx_empty    <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= w_count_nxt;
            tx_full  <= (w_count_nxt == FULL_CNT);
            tx_empty <= (w_count_nxt == '0);
            // A dropped write beats a same-cycle clear
            if (tx_wr && tx_full)
                tx_overflow <= 1'b1;
            else if (tx_overflow_clear)
                tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= (^w_head) ^ ODD_BIT;
                        r_tick   <= '0;
                        tx       <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        tx      <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else if (tx_clk_en) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_tick <= '0;
                        if (r_bit == 3'd7) begin
                            if (HAS_PAR) begin
                                tx      <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            tx      <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else if (tx_clk_en) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_last) begin
                        r_tick  <= '0;
                        tx      <= 1'b1;
                        r_state <= S_STOP;
                    end else if (tx_clk_en) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_STOP: begin
                    if (w_last) begin
                        r_tick <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_parity <= (^w_head) ^ ODD_BIT;
                            tx       <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (tx_clk_en) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_tick  <= '0;
                    tx      <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (8N1, 8E1, 8O1) checked
// against a queue of expected line frames decoded cycle by cycle.
module tb_uart_transmitter;

    logic       sys_clk;
    logic       rst;
    logic       tx_clk_en;
    logic       ovf_clr;
    logic [7:0] tx_data;
    logic [2:0] wr;
    logic [2:0] tx_o;
    logic [2:0] busy_o;
    logic [2:0] full_o;
    logic [2:0] empty_o;
    logic [2:0] ovf_o;

    int checks;
    int errors;

    logic [10:0] sb[$];

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[8];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_transmitter u_n (
        .sys_clk(sys_clk), .rst(rst), .tx_clk_en(tx_clk_en),
        .tx_data(tx_data), .tx_wr(wr[0]), .tx_full(full_o[0]),
        .tx_empty(empty_o[0]), .tx_busy(busy_o[0]),
        .tx_overflow(ovf_o[0]), .tx_overflow_clear(ovf_clr),
        .tx(tx_o[0])
    );

    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_e (
        .sys_clk(sys_clk), .rst(rst), .tx_clk_en(tx_clk_en),
        .tx_data(tx_data), .tx_wr(wr[1]), .tx_full(full_o[1]),
        .tx_empty(empty_o[1]), .tx_busy(busy_o[1]),
        .tx_overflow(ovf_o[1]), .tx_overflow_clear(ovf_clr),
        .tx(tx_o[1])
    );

    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_o (
        .sys_clk(sys_clk), .rst(rst), .tx_clk_en(tx_clk_en),
        .tx_data(tx_data), .tx_wr(wr[2]), .tx_full(full_o[2]),
        .tx_empty(empty_o[2]), .tx_busy(busy_o[2]),
        .tx_overflow(ovf_o[2]), .tx_overflow_clear(ovf_clr),
        .tx(tx_o[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input int sel, input logic [7:0] d);
        tx_data = d;
        wr[sel] = 1'b1;
        @(negedge sys_clk);
        wr = 3'b000;
    endtask

    // Wait for a start bit, then compare every cycle against popped frames
    task automatic rx_check(input int sel, input int nfr,
                            output logic e_first, output logic e_last);
        int          flen;
        int          mism;
        int          blen;
        bit          seen;
        logic [10:0] exp;
        flen    = (sel == 0) ? 10 : 11;
        seen    = 1'b0;
        blen    = 0;
        e_first = 1'b0;
        e_last  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (tx_o[sel] == 1'b0) seen = 1'b1;
            else @(negedge sys_clk);
        end
        chk("rx_start_seen", int'(seen), 1);
        if (!seen) return;
        for (int f = 0; f < nfr; f++) begin
            chk("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) exp = sb.pop_front();
            else exp = '1;
            mism = 0;
            for (int c = 0; c < flen * 16; c++) begin
                if (tx_o[sel] !== exp[c / 16]) mism++;
                if (busy_o[sel]) blen++;
                if (c == 8) begin
                    if (f == 0) e_first = empty_o[sel];
                    e_last = empty_o[sel];
                end
                @(negedge sys_clk);
            end
            chk($sformatf("frame_bits_%03h", exp), mism, 0);
        end
        chk("busy_len", blen, nfr * flen * 16);
        chk("idle_tx", int'(tx_o[sel]), 1);
        chk("idle_busy", int'(busy_o[sel]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic ef;
        logic el;
        int   low_cnt;
        int   busy_cnt;

        vecs[0] = '{0, 8'h55, 11'b0_1_01010101_0};
        vecs[1] = '{0, 8'h00, 11'b0_1_00000000_0};
        vecs[2] = '{0, 8'hFF, 11'b0_1_11111111_0};
        vecs[3] = '{0, 8'h81, 11'b0_1_10000001_0};
        vecs[4] = '{1, 8'h07, 11'b1_1_00000111_0};
        vecs[5] = '{1, 8'h03, 11'b1_0_00000011_0};
        vecs[6] = '{2, 8'h07, 11'b1_0_00000111_0};
        vecs[7] = '{2, 8'h00, 11'b1_1_00000000_0};

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        tx_clk_en = 1'b0;
        ovf_clr   = 1'b0;
        tx_data   = 8'h00;
        wr        = 3'b000;

        repeat (3) @(negedge sys_clk);
        chk("rst_tx", int'(tx_o), 7);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_empty", int'(empty_o), 7);
        chk("rst_full", int'(full_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        rst       = 1'b0;
        tx_clk_en = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 8; i++) begin
            sb.push_back(vecs[i].frame);
            wr_byte(vecs[i].sel, vecs[i].data);
            rx_check(vecs[i].sel, 1, ef, el);
        end

        // back-to-back frames with no idle gap
        sb.push_back(11'b0_1_10100101_0);
        wr_byte(0, 8'hA5);
        sb.push_back(11'b0_1_00111100_0);
        wr_byte(0, 8'h3C);
        rx_check(0, 2, ef, el);
        chk("b2b_empty_first", int'(ef), 0);
        chk("b2b_empty_second", int'(el), 1);

        // fill with ticks stopped, overflow on 5th write
        tx_clk_en = 1'b0;
        @(negedge sys_clk);
        tx_data = 8'h11; wr[0] = 1'b1;
        @(negedge sys_clk);
        tx_data = 8'h22;
        @(negedge sys_clk);
        tx_data = 8'h33;
        @(negedge sys_clk);
        chk("fifo_full_3", int'(full_o[0]), 0);
        tx_data = 8'h44;
        @(negedge sys_clk);
        chk("fifo_full_4", int'(full_o[0]), 1);
        chk("fifo_ovf_4", int'(ovf_o[0]), 0);
        chk("fifo_empty_4", int'(empty_o[0]), 0);
        tx_data = 8'h99;
        @(negedge sys_clk);
        wr = 3'b000;
        chk("fifo_full_5", int'(full_o[0]), 1);
        chk("fifo_ovf_5", int'(ovf_o[0]), 1);
        wr[0] = 1'b1; ovf_clr = 1'b1;
        @(negedge sys_clk);
        wr = 3'b000; ovf_clr = 1'b0;
        chk("ovf_set_wins", int'(ovf_o[0]), 1);
        ovf_clr = 1'b1;
        @(negedge sys_clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf_o[0]), 0);
        sb.push_back(11'b0_1_00010001_0);
        sb.push_back(11'b0_1_00100010_0);
        sb.push_back(11'b0_1_00110011_0);
        sb.push_back(11'b0_1_01000100_0);
        tx_clk_en = 1'b1;
        rx_check(0, 4, ef, el);
        chk("drain_empty_first", int'(ef), 0);
        chk("drain_sb_left", sb.size(), 0);

        // reset during data bit 3 with two bytes still queued
        wr_byte(0, 8'hFF);
        wr_byte(0, 8'h12);
        wr_byte(0, 8'h34);
        repeat (70) @(negedge sys_clk);
        chk("pre_rst_busy", int'(busy_o[0]), 1);
        chk("pre_rst_empty", int'(empty_o[0]), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", int'(tx_o[0]), 1);
        chk("mid_rst_busy", int'(busy_o[0]), 0);
        chk("mid_rst_empty", int'(empty_o[0]), 1);
        chk("mid_rst_full", int'(full_o[0]), 0);
        @(negedge sys_clk);
        rst      = 1'b0;
        low_cnt  = 0;
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_o[0] !== 1'b1) low_cnt++;
            if (busy_o[0] !== 1'b0) busy_cnt++;
            @(negedge sys_clk);
        end
        chk("post_rst_tx_low", low_cnt, 0);
        chk("post_rst_busy", busy_cnt, 0);
        chk("post_rst_empty", int'(empty_o[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter SAMPLE_TIMES, default 16, giving tx_clk_en ticks per bit period (same 16x enable that feeds uart_receiver).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), giving the transmit FIFO entry count.
REQ-003 The block SHALL have parameter PARITY_EN, default 0, where 1 inserts a parity bit after data bit 7.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port tx_clk_en, input, 1 bit: 16x baud tick, one sys_clk cycle wide.
REQ-008 The block SHALL have port tx_data, input, 8 bits: byte to queue.
REQ-009 The block SHALL have port tx_wr, input, 1 bit: write strobe, sampled every sys_clk cycle and not gated by tx_clk_en.
REQ-010 The block SHALL have port tx_full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-011 The block SHALL have port tx_empty, output, 1 bit: FIFO holds 0 entries.
REQ-012 The block SHALL have port tx_busy, output, 1 bit: the serializer is not in IDLE.
REQ-013 The block SHALL have port tx_overflow, output, 1 bit: sticky flag set by a write dropped while full.
REQ-014 The block SHALL have port tx_overflow_clear, input, 1 bit: clears tx_overflow.
REQ-015 The block SHALL have port tx, output, 1 bit: registered serial line, idle high.

Function
REQ-016 The FIFO SHALL accept a write when tx_wr=1 and tx_full=0, storing tx_data at the write pointer; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 A write with tx_full=1 SHALL be dropped and SHALL set tx_overflow, even if a pop occurs in the same cycle.
REQ-018 tx_full and tx_empty SHALL be registered and derived from an occupancy count of width clog2(FIFO_DEPTH)+1; a simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-019 tx_overflow_clear=1 SHALL clear tx_overflow unless an overflow occurs in the same cycle, in which case set wins.
REQ-020 The serializer SHALL use states IDLE, START, DATA, PARITY, STOP and advance only on cycles with tx_clk_en=1.
REQ-021 In IDLE, on a tick with tx_empty=0, the serializer SHALL pop one byte into a shift register, drive tx=0, clear the tick counter, and enter START.
REQ-022 Each of START, each data bit, PARITY and STOP SHALL last exactly SAMPLE_TIMES ticks; data SHALL be sent LSB first with bit index 0..7.
REQ-023 After data bit 7 the serializer SHALL enter PARITY if PARITY_EN=1, otherwise STOP; the parity value SHALL be the XOR of the 8 bits, inverted when PARITY_ODD=1.
REQ-024 In STOP, tx SHALL be 1; at its last tick the serializer SHALL go to START with an immediate pop if the FIFO is non-empty (no idle gap), otherwise to IDLE.
REQ-025 A frame SHALL be 10*SAMPLE_TIMES ticks long (11*SAMPLE_TIMES with parity), and tx SHALL change only on tx_clk_en cycles.
REQ-026 A byte written while the FIFO is empty SHALL start no earlier than the first tick after the write cycle.
REQ-027 tx_busy SHALL be 1 from the START entry edge until the IDLE entry edge.
REQ-028 Illegal state encodings SHALL return to IDLE with tx=1.

Reset
REQ-029 While rst=1, outputs SHALL be tx=1, tx_busy=0, tx_empty=1, tx_full=0, tx_overflow=0; the state SHALL be IDLE and pointers, count and counters SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL force tx high asynchronously, abandon the frame and discard all FIFO contents.
REQ-031 The first write accepted SHALL be on the first rising edge after rst deasserts.

Verification
REQ-032 tx_clk_en every cycle, write 0x55 -> tx=0 for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then 1 for 16 cycles; tx_busy falls after 160 ticks.
REQ-033 Write 0xA5, 0x3C back-to-back -> two 160-tick frames with no idle tick between them; tx_empty=1 after the second pop.
REQ-034 FIFO_DEPTH=4, tx_clk_en held 0, write 5 bytes -> tx_full=1 after the 4th write, 5th write dropped, tx_overflow=1; pulse tx_overflow_clear -> tx_overflow=0.
REQ-035 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 176 ticks; with PARITY_ODD=1 -> parity bit 0.
REQ-036 Assert rst during data bit 3 of 0xFF with 2 bytes queued -> tx=1 immediately, tx_empty=1, tx_busy=0; no frame follows release.
